// File: rtl/spike_packet_decoder_if.sv
// Flit-in / spike-out bundle between a router output port, the decoder and the neuron datapath.
// master = flit source plus spike consumer, slave = the decoder.
interface spike_packet_decoder_if #(
   parameter int FLIT_SIZE  = 4,
   parameter int NUM_AXONS  = 2,
   parameter int STEP_WIDTH = 8
);
   logic                  start;
   logic [FLIT_SIZE-1:0]  flit_in;
   logic                  flit_valid;
   logic                  full;
   logic [NUM_AXONS-1:0]  spike_out;
   logic                  spike_valid;
   logic [STEP_WIDTH-1:0] step_cnt;
   logic                  pkt_accept;
   logic                  pkt_drop;

   modport master (
      output start, flit_in, flit_valid,
      input  full, spike_out, spike_valid, step_cnt, pkt_accept, pkt_drop
   );

   modport slave (
      input  start, flit_in, flit_valid,
      output full, spike_out, spike_valid, step_cnt, pkt_accept, pkt_drop
   );
endinterface

// File: rtl/spike_packet_decoder.sv
// Reassembles flits into spike packets, filters them by time-step tag and axon id, and
// double-buffers accepted spikes into spike_out on every start pulse.
module spike_packet_decoder #(
   parameter int PACKET_SIZE        = 32,
   parameter int FLIT_SIZE          = 4,
   parameter int NUM_AXONS          = 2,
   parameter int AXON_CNT_BIT_WIDTH = 1,
   parameter int STEP_WIDTH         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   spike_packet_decoder_if.slave bus
);
   localparam int FLITS  = PACKET_SIZE / FLIT_SIZE;
   localparam int CNT_W  = $clog2(FLITS + 1);
   localparam int ID_W   = 16;
   // Only tag + id are kept; the routing header simply falls off the top of the shifter.
   localparam int KEEP_W = STEP_WIDTH + ID_W;

   typedef struct packed {
      logic [STEP_WIDTH-1:0] tag;
      logic [ID_W-1:0]       id;
   } pkt_t;

   typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [KEEP_W-1:0]     sreg;
   pkt_t                  pkt;
   logic [NUM_AXONS-1:0]  accum, spike_out_r, hit;
   logic [STEP_WIDTH-1:0] step_cnt_r;
   logic                  spike_valid_r;
   logic                  full_c, accept_c, drop_c;
   logic                  tag_ok, id_ok, shift_en;

   assign pkt      = sreg;
   assign shift_en = bus.flit_valid && (state != DECODE);
   assign tag_ok   = (pkt.tag == step_cnt_r);
   assign id_ok    = (pkt.id[ID_W-1:AXON_CNT_BIT_WIDTH] == '0) && (pkt.id < ID_W'(NUM_AXONS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.flit_valid) state_nxt = RECV;
         RECV:    if (bus.flit_valid && cnt == CNT_W'(FLITS - 1)) state_nxt = DECODE;
         DECODE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A flit arriving while DECODE is busy is discarded and reported as a drop.
   always_comb begin
      full_c   = 1'b0;
      accept_c = 1'b0;
      drop_c   = 1'b0;
      if (state == DECODE) begin
         full_c   = 1'b1;
         accept_c = tag_ok && id_ok;
         drop_c   = !(tag_ok && id_ok) || bus.flit_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (shift_en) begin
         sreg <= {sreg[KEEP_W-FLIT_SIZE-1:0], bus.flit_in};
         cnt  <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      end else if (state == DECODE) begin
         cnt  <= '0;
      end
   end

   for (genvar a = 0; a < NUM_AXONS; a++) begin : g_axon
      assign hit[a] = accept_c && (pkt.id[AXON_CNT_BIT_WIDTH-1:0] == AXON_CNT_BIT_WIDTH'(a));
   end

   // A packet decoded in the start cycle was tagged for the closing step, so it joins spike_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accum         <= '0;
         spike_out_r   <= '0;
         step_cnt_r    <= '0;
         spike_valid_r <= 1'b0;
      end else begin
         spike_valid_r <= bus.start;
         if (bus.start) begin
            spike_out_r <= accum | hit;
            accum       <= '0;
            step_cnt_r  <= step_cnt_r + STEP_WIDTH'(1);
         end else begin
            accum       <= accum | hit;
         end
      end
   end

   assign bus.full        = full_c;
   assign bus.pkt_accept  = accept_c;
   assign bus.pkt_drop    = drop_c;
   assign bus.spike_out   = spike_out_r;
   assign bus.spike_valid = spike_valid_r;
   assign bus.step_cnt    = step_cnt_r;
endmodule

// File: tb/tb_spike_packet_decoder.sv
// Randomized scoreboard bench for spike_packet_decoder: a step/accumulator model predicts
// every accept/drop pulse and every spike_out swap; a negedge monitor consumes the predictions.
module tb_spike_packet_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spike_packet_decoder_if #(.FLIT_SIZE(4), .NUM_AXONS(2), .STEP_WIDTH(8)) bus ();

   spike_packet_decoder #(
      .PACKET_SIZE(32), .FLIT_SIZE(4), .NUM_AXONS(2), .AXON_CNT_BIT_WIDTH(1), .STEP_WIDTH(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct { bit acc; bit drop; } pkt_exp_t;
   typedef struct { bit [1:0] spk; bit [7:0] step; } spk_exp_t;

   pkt_exp_t pkt_q[$];
   spk_exp_t spk_q[$];
   pkt_exp_t pe;
   spk_exp_t se;

   int total = 0;
   int bad   = 0;

   // reference state: current time step and spikes gathered for it
   int     m_step  = 0;
   bit [1:0] m_accum = 2'b00;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void model_decode(input bit [7:0] tag, input bit [15:0] id, input bit extra);
      pkt_exp_t e;
      e.acc  = (int'(tag) == m_step) && (id < 16'd2);
      e.drop = !e.acc || extra;
      pkt_q.push_back(e);
      if (e.acc) m_accum[id[0]] = 1'b1;
   endfunction

   function automatic void model_start();
      spk_exp_t e;
      m_step = (m_step + 1) % 256;
      e.spk  = m_accum;
      e.step = 8'(m_step);
      spk_q.push_back(e);
      m_accum = 2'b00;
   endfunction

   task automatic slot(input logic s, input logic v, input logic [3:0] f);
      @(posedge clk);
      #1;
      bus.start      = s;
      bus.flit_valid = v;
      bus.flit_in    = f;
   endtask

   task automatic do_start();
      slot(1'b1, 1'b0, 4'h0);
      model_start();
   endtask

   // mid_start in 1..7 inserts a start pulse before that flit; -1 disables it
   task automatic send_pkt(input bit [7:0] hdr, input bit [7:0] tag, input bit [15:0] id,
                           input bit st_dec, input bit fl_dec, input int gapmax, input int mid_start);
      logic [31:0] p;
      p = {hdr, tag, id};
      for (int i = 0; i < 8; i++) begin
         if (i == mid_start) begin
            slot(1'b1, 1'b0, 4'h0);
            model_start();
         end
         repeat ($urandom_range(gapmax, 0)) slot(1'b0, 1'b0, 4'($urandom));
         slot(1'b0, 1'b1, p[31-4*i -: 4]);
      end
      slot(st_dec, fl_dec, 4'($urandom));
      model_decode(tag, id, fl_dec);
      if (st_dec) model_start();
      @(negedge clk);
      chk("full_decode", int'(bus.full), 1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.pkt_accept || bus.pkt_drop) begin
            if (pkt_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pkt_unexpected: accept=%0b drop=%0b, none expected", bus.pkt_accept, bus.pkt_drop);
            end else begin
               pe = pkt_q.pop_front();
               chk("pkt_accept", int'(bus.pkt_accept), int'(pe.acc));
               chk("pkt_drop", int'(bus.pkt_drop), int'(pe.drop));
            end
         end
         if (bus.spike_valid) begin
            if (spk_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spike_unexpected: spike_out=%b, none expected", bus.spike_out);
            end else begin
               se = spk_q.pop_front();
               chk("spike_out", int'(bus.spike_out), int'(se.spk));
               chk("step_cnt", int'(bus.step_cnt), int'(se.step));
            end
         end
      end
   end

   initial begin
      bit [7:0]  tag;
      bit [15:0] id;
      int        r;
      bus.start      = 1'b0;
      bus.flit_valid = 1'b0;
      bus.flit_in    = 4'h0;

      #12;
      chk("rst_spike_out", int'(bus.spike_out), 0);
      chk("rst_step_cnt", int'(bus.step_cnt), 0);
      chk("rst_full", int'(bus.full), 0);
      chk("rst_spike_valid", int'(bus.spike_valid), 0);
      chk("rst_pkt_accept", int'(bus.pkt_accept), 0);
      chk("rst_pkt_drop", int'(bus.pkt_drop), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      slot(1'b0, 1'b0, 4'h0);

      // first step boundary, nothing accumulated
      do_start();
      slot(1'b0, 1'b0, 4'h0);

      // tag 1 / axon 1: flits 0,0,0,1,0,0,0,1
      send_pkt(8'h00, 8'(m_step), 16'd1, 1'b0, 1'b0, 0, -1);
      do_start();

      // both axons, axon 1 twice
      send_pkt(8'($urandom), 8'(m_step), 16'd0, 1'b0, 1'b0, 3, -1);
      send_pkt(8'($urandom), 8'(m_step), 16'd1, 1'b0, 1'b0, 3, -1);
      send_pkt(8'($urandom), 8'(m_step), 16'd1, 1'b0, 1'b0, 3, -1);
      do_start();

      // stale tag and out-of-range ids
      send_pkt(8'h5a, 8'(m_step - 1), 16'd1, 1'b0, 1'b0, 1, -1);
      send_pkt(8'h5a, 8'(m_step), 16'd2, 1'b0, 1'b0, 1, -1);
      send_pkt(8'h5a, 8'(m_step), 16'h8001, 1'b0, 1'b0, 1, -1);
      do_start();

      // decode coinciding with start, then an empty step
      send_pkt(8'h11, 8'(m_step), 16'd0, 1'b1, 1'b0, 1, -1);
      do_start();

      // flit during DECODE is dropped and the following packet is intact
      send_pkt(8'h22, 8'(m_step), 16'd1, 1'b0, 1'b1, 1, -1);
      send_pkt(8'h33, 8'(m_step), 16'd0, 1'b0, 1'b0, 1, -1);
      do_start();

      // partial packet across a start is tagged for the new step
      send_pkt(8'h44, 8'(m_step + 1), 16'd1, 1'b0, 1'b0, 1, 4);
      do_start();

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(3, 0);
         case (r)
            0:       tag = 8'(m_step);
            1:       tag = 8'(m_step - 1);
            2:       tag = 8'(m_step + 1);
            default: tag = 8'($urandom);
         endcase
         r = $urandom_range(5, 0);
         case (r)
            0, 1:    id = 16'd0;
            2, 3:    id = 16'd1;
            4:       id = 16'd2;
            default: id = 16'($urandom);
         endcase
         send_pkt(8'($urandom), tag, id, ($urandom_range(4, 0) == 0), ($urandom_range(4, 0) == 0),
                  2, ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : -1);
         if ($urandom_range(9, 0) < 3) do_start();
      end
      do_start();
      repeat (3) slot(1'b0, 1'b0, 4'h0);

      // async reset after 3 flits
      slot(1'b0, 1'b1, 4'h1);
      slot(1'b0, 1'b1, 4'h2);
      slot(1'b0, 1'b1, 4'h3);
      #3;
      rst_n          = 1'b0;
      bus.flit_valid = 1'b0;
      #1;
      chk("midrst_full", int'(bus.full), 0);
      chk("midrst_step_cnt", int'(bus.step_cnt), 0);
      chk("midrst_spike_out", int'(bus.spike_out), 0);
      m_step  = 0;
      m_accum = 2'b00;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_pkt(8'hff, 8'h00, 16'd1, 1'b0, 1'b0, 0, -1);
      do_start();

      // step counter wrap, then tag 0 accepted
      while (m_step != 255) do_start();
      do_start();
      send_pkt(8'h00, 8'h00, 16'd0, 1'b0, 1'b0, 1, -1);
      do_start();

      repeat (5) slot(1'b0, 1'b0, 4'h0);
      chk("pkt_q_drained", pkt_q.size(), 0);
      chk("spk_q_drained", spk_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
